// File: rtl/ps2_move_tracker.sv
// Purpose: decode PS/2 set-2 scan bytes into per-player held-key bitmaps, move codes and move strobes.
// Latency: 1 cycle from rx_done_tick to held/move/move_stb.
// Backpressure: none; every rx_done_tick byte is consumed. Optional auto-repeat via `define MOVE_REPEAT_EN.
module ps2_move_tracker #(
  parameter int NUM_PLAYERS   = 2,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx_done_tick,
  input  logic [7:0]                 rx_data,
  output logic [5*NUM_PLAYERS-1:0]   held,
  output logic [3*NUM_PLAYERS-1:0]   move,
  output logic [NUM_PLAYERS-1:0]     move_stb
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EXT     = 2'd1;
  localparam logic [1:0] S_BRK     = 2'd2;
  localparam logic [1:0] S_EXT_BRK = 2'd3;

  logic [1:0]               state, state_nxt;
  logic                     key_vld, key_ext, key_make, clr_all;
  logic [3:0]               key_map;   // {hit, bit index}
  logic [5*NUM_PLAYERS-1:0] held_nxt;
  logic [NUM_PLAYERS-1:0]   press;
  logic [NUM_PLAYERS-1:0]   rpt_stb;

  // Unprefixed codes belong to player 0: bit order {action, right, left, down, up}
  function automatic logic [3:0] map_std(input logic [7:0] code);
    case (code)
      8'h1D:   map_std = {1'b1, 3'd0};
      8'h1B:   map_std = {1'b1, 3'd1};
      8'h1C:   map_std = {1'b1, 3'd2};
      8'h23:   map_std = {1'b1, 3'd3};
      8'h29:   map_std = {1'b1, 3'd4};
      default: map_std = 4'b0000;
    endcase
  endfunction

  // E0-prefixed codes belong to player 1 (arrow keys + right Ctrl)
  function automatic logic [3:0] map_ext(input logic [7:0] code);
    case (code)
      8'h75:   map_ext = {1'b1, 3'd0};
      8'h72:   map_ext = {1'b1, 3'd1};
      8'h6B:   map_ext = {1'b1, 3'd2};
      8'h74:   map_ext = {1'b1, 3'd3};
      8'h14:   map_ext = {1'b1, 3'd4};
      default: map_ext = 4'b0000;
    endcase
  endfunction

  // Fixed priority: action > up > down > left > right
  function automatic logic [2:0] move_enc(input logic [4:0] h);
    if (h[4])      move_enc = 3'b101;
    else if (h[0]) move_enc = 3'b001;
    else if (h[1]) move_enc = 3'b010;
    else if (h[2]) move_enc = 3'b011;
    else if (h[3]) move_enc = 3'b100;
    else           move_enc = 3'b000;
  endfunction

  // Parser: classify the incoming byte and pick the next prefix state
  always_comb begin
    state_nxt = state;
    key_vld   = 1'b0;
    key_ext   = 1'b0;
    key_make  = 1'b1;
    clr_all   = 1'b0;
    if (rx_done_tick) begin
      case (state)
        S_IDLE: begin
          if (rx_data == 8'hE0)      state_nxt = S_EXT;
          else if (rx_data == 8'hF0) state_nxt = S_BRK;
          else if (rx_data == 8'hAA || rx_data == 8'h00 || rx_data == 8'hFF) clr_all = 1'b1;
          else key_vld = 1'b1;
        end
        S_EXT: begin
          if (rx_data == 8'hF0) state_nxt = S_EXT_BRK;
          else begin
            key_vld   = 1'b1;
            key_ext   = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        S_BRK: begin
          key_vld   = 1'b1;
          key_make  = 1'b0;
          state_nxt = S_IDLE;
        end
        default: begin
          key_vld   = 1'b1;
          key_ext   = 1'b1;
          key_make  = 1'b0;
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign key_map = key_ext ? map_ext(rx_data) : map_std(rx_data);

  // Next held bitmap; player-1 keys find no slot when only one player is built
  always_comb begin
    held_nxt = clr_all ? '0 : held;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      for (int b = 0; b < 5; b++) begin
        if (key_vld && key_map[3] && (int'(key_ext) == p) && (key_map[2:0] == 3'(b)))
          held_nxt[5*p+b] = key_make;
      end
    end
  end

  // A new press is any held bit rising for that player
  always_comb begin
    press = '0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      press[p] = |(held_nxt[5*p +: 5] & ~held[5*p +: 5]);
  end

`ifdef MOVE_REPEAT_EN
  localparam int CW = $clog2(REPEAT_CYCLES);
  logic [CW-1:0] rpt_cnt [NUM_PLAYERS];

  // Repeat fires when a running counter wraps and a key is still held after this cycle
  always_comb begin
    rpt_stb = '0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      rpt_stb[p] = (move[3*p +: 3] != 3'b000) && (rpt_cnt[p] == CW'(REPEAT_CYCLES-1))
                   && (|held_nxt[5*p +: 5]);
  end

  // Per-player repeat counters: restart on a press or full release, run while a move is shown
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (reset)
        rpt_cnt[p] <= '0;
      else if (press[p] || !(|held_nxt[5*p +: 5]))
        rpt_cnt[p] <= '0;
      else if (move[3*p +: 3] != 3'b000)
        rpt_cnt[p] <= (rpt_cnt[p] == CW'(REPEAT_CYCLES-1)) ? '0 : rpt_cnt[p] + 1'b1;
    end
  end
`else
  assign rpt_stb = '0;
`endif

  // Registered outputs and parser state
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      held     <= '0;
      move     <= '0;
      move_stb <= '0;
    end else begin
      state <= state_nxt;
      held  <= held_nxt;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        move[3*p +: 3] <= move_enc(held_nxt[5*p +: 5]);
        move_stb[p]    <= press[p] | rpt_stb[p];
      end
    end
  end

endmodule

// File: tb/tb_ps2_move_tracker.sv
module tb_ps2_move_tracker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;

  logic [9:0] held2;
  logic [5:0] move2;
  logic [1:0] stb2;
  logic [4:0] held1;
  logic [2:0] move1;
  logic [0:0] stb1;

  ps2_move_tracker #(.NUM_PLAYERS(2), .REPEAT_CYCLES(8)) dut2 (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .held(held2), .move(move2), .move_stb(stb2)
  );

  ps2_move_tracker #(.NUM_PLAYERS(1), .REPEAT_CYCLES(8)) dut1 (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .held(held1), .move(move1), .move_stb(stb1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [9:0] h2;
    logic [5:0] m2;
    logic [1:0] s2;
    logic [4:0] h1;
    logic [2:0] m1;
    logic       s1;
  } exp_t;

  exp_t       sb_q[$];
  int         mst;      // 0 idle, 1 ext, 2 brk, 3 ext_brk
  logic [9:0] mh2;
  logic [4:0] mh1;

  function automatic logic [2:0] pri(input logic [4:0] h);
    if (h[4])      return 3'd5;
    else if (h[0]) return 3'd1;
    else if (h[1]) return 3'd2;
    else if (h[2]) return 3'd3;
    else if (h[3]) return 3'd4;
    return 3'd0;
  endfunction

  function automatic int key_p0(input logic [7:0] b);
    case (b)
      8'h1D: return 0;
      8'h1B: return 1;
      8'h1C: return 2;
      8'h23: return 3;
      8'h29: return 4;
      default: return -1;
    endcase
  endfunction

  function automatic int key_p1(input logic [7:0] b);
    case (b)
      8'h75: return 0;
      8'h72: return 1;
      8'h6B: return 2;
      8'h74: return 3;
      8'h14: return 4;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    mst = 0;
    mh2 = '0;
    mh1 = '0;
    sb_q.delete();
  endtask

  task automatic model_key(input bit ext, input logic [7:0] b, input logic make);
    int k;
    if (!ext) begin
      k = key_p0(b);
      if (k >= 0) begin
        mh2[k] = make;
        mh1[k] = make;
      end
    end else begin
      k = key_p1(b);
      if (k >= 0) mh2[5+k] = make;
    end
  endtask

  // Reference parser: updates model state and pushes the expected post-tick outputs
  task automatic model_byte(input logic [7:0] b);
    logic [9:0] o2;
    logic [4:0] o1;
    exp_t e;
    o2 = mh2;
    o1 = mh1;
    case (mst)
      0: begin
        if (b == 8'hE0) mst = 1;
        else if (b == 8'hF0) mst = 2;
        else if (b == 8'hAA || b == 8'h00 || b == 8'hFF) begin
          mh2 = '0;
          mh1 = '0;
        end else model_key(1'b0, b, 1'b1);
      end
      1: begin
        if (b == 8'hF0) mst = 3;
        else begin
          model_key(1'b1, b, 1'b1);
          mst = 0;
        end
      end
      2: begin model_key(1'b0, b, 1'b0); mst = 0; end
      default: begin model_key(1'b1, b, 1'b0); mst = 0; end
    endcase
    e.h2 = mh2;
    e.m2 = {pri(mh2[9:5]), pri(mh2[4:0])};
    e.s2 = {|(mh2[9:5] & ~o2[9:5]), |(mh2[4:0] & ~o2[4:0])};
    e.h1 = mh1;
    e.m1 = pri(mh1);
    e.s1 = |(mh1 & ~o1);
    sb_q.push_back(e);
  endtask

  // Drive one byte, score the tick+1 outputs, then confirm the strobe dropped
  task automatic send_byte(input logic [7:0] b);
    exp_t e, o;
    @(negedge clk);
    rx_done_tick = 1'b1;
    rx_data      = b;
    model_byte(b);
    @(posedge clk);
    #1;
    rx_done_tick = 1'b0;
    o = {held2, move2, stb2, held1, move1, stb1[0]};
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty byte=%h", b);
    end else begin
      e = sb_q.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL byte_%h: got h2=%b m2=%b s2=%b h1=%b m1=%b s1=%b want h2=%b m2=%b s2=%b h1=%b m1=%b s1=%b",
                 b, o.h2, o.m2, o.s2, o.h1, o.m1, o.s1, e.h2, e.m2, e.s2, e.h1, e.m1, e.s1);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if ({stb2, stb1} !== 3'b000) begin
      errors++;
      $display("FAIL stb_one_cycle byte=%h: got %b want 000", b, {stb2, stb1});
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset        = 1'b1;
    rx_done_tick = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset        = 1'b1;
    rx_done_tick = 1'b1;    // coincident tick must be ignored
    rx_data      = 8'h1D;
    @(posedge clk);
    #1;
    checks++;
    if ({held2, move2, stb2, held1, move1, stb1} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {held2, move2, stb2, held1, move1, stb1});
    end
    @(negedge clk);
    rx_done_tick = 1'b0;
    reset        = 1'b0;
    model_reset();
  endtask

  task automatic test_press_release();
    apply_reset();
    send_byte(8'h1D);
    checks++;
    if (held2[4:0] !== 5'b00001 || move2 !== 6'b000_001) begin
      errors++;
      $display("FAIL press_up: got held=%b move=%b want 00001/000001", held2[4:0], move2);
    end
    send_byte(8'hF0);
    send_byte(8'h1D);
    checks++;
    if (held2 !== 10'd0 || move2 !== 6'd0) begin
      errors++;
      $display("FAIL release_up: got held=%b move=%b want 0/0", held2, move2);
    end
  endtask

  task automatic test_priority();
    apply_reset();
    send_byte(8'h1C);
    checks++;
    if (move2[2:0] !== 3'b011) begin errors++; $display("FAIL prio_left: got %b want 011", move2[2:0]); end
    send_byte(8'h29);
    checks++;
    if (move2[2:0] !== 3'b101) begin errors++; $display("FAIL prio_action: got %b want 101", move2[2:0]); end
    send_byte(8'hF0);
    send_byte(8'h29);
    checks++;
    if (move2[2:0] !== 3'b011) begin errors++; $display("FAIL prio_back_left: got %b want 011", move2[2:0]); end
  endtask

  task automatic test_player1();
    apply_reset();
    send_byte(8'hE0);
    send_byte(8'h75);
    checks++;
    if (move2 !== 6'b001_000 || held1 !== 5'd0 || move1 !== 3'd0) begin
      errors++;
      $display("FAIL p1_up: got move2=%b held1=%b move1=%b want 001000/0/0", move2, held1, move1);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    checks++;
    if (move2 !== 6'd0 || held2 !== 10'd0) begin
      errors++;
      $display("FAIL p1_release: got move2=%b held2=%b want 0/0", move2, held2);
    end
  endtask

  task automatic test_typematic();
    apply_reset();
    send_byte(8'h1D);
    send_byte(8'h1D);
    send_byte(8'h1D);
    checks++;
    if (held2 !== 10'b00000_00001) begin
      errors++;
      $display("FAIL typematic_held: got %b want 0000000001", held2);
    end
    send_byte(8'hAA);
    checks++;
    if (held2 !== 10'd0 || held1 !== 5'd0) begin
      errors++;
      $display("FAIL kbd_reset_clear: got %b/%b want 0/0", held2, held1);
    end
  endtask

  task automatic test_prefix_reset();
    apply_reset();
    send_byte(8'hE0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({held2, move2, stb2, held1, move1, stb1} !== '0) begin
      errors++;
      $display("FAIL prefix_reset_outputs: got %h want 0", {held2, move2, stb2, held1, move1, stb1});
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    send_byte(8'h1D);
    checks++;
    if (move2 !== 6'b000_001 || move1 !== 3'b001) begin
      errors++;
      $display("FAIL prefix_discard: got move2=%b move1=%b want 000001/001", move2, move1);
    end
  endtask

  task automatic test_unmapped();
    apply_reset();
    send_byte(8'hE0);
    send_byte(8'h1D);   // extended form of a player-0 code: ignored
    send_byte(8'hE1);   // pause-sequence lead: ignored
    send_byte(8'h33);   // unmapped plain key
    checks++;
    if (held2 !== 10'd0 || move2 !== 6'd0) begin
      errors++;
      $display("FAIL unmapped: got held=%b move=%b want 0/0", held2, move2);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    send_byte(8'h1D);
    send_byte(8'hE0);
    send_byte(8'h74);
    checks++;
    if (move2 !== 6'b100_001 || held2 !== 10'b01000_00001) begin
      errors++;
      $display("FAIL two_players: got move=%b held=%b want 100001/0100000001", move2, held2);
    end
  endtask

  task automatic test_repeat();
    logic exp_stb;
    apply_reset();
    @(negedge clk);
    rx_done_tick = 1'b1;
    rx_data      = 8'h23;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      rx_done_tick = 1'b0;
`ifdef MOVE_REPEAT_EN
      exp_stb = (k <= 41) && (k % 8 == 1);
`else
      exp_stb = (k == 1);
`endif
      checks++;
      if (stb2 !== {1'b0, exp_stb} || stb1[0] !== exp_stb) begin
        errors++;
        $display("FAIL repeat_stb k=%0d: got %b/%b want %b", k, stb2, stb1, exp_stb);
      end
      if (k == 20 || k == 42) begin
        checks++;
        if (held2[4:0] !== ((k == 20) ? 5'b01000 : 5'b00000)) begin
          errors++;
          $display("FAIL repeat_held k=%0d: got %b", k, held2[4:0]);
        end
      end
      if (k == 40) begin
        rx_done_tick = 1'b1;
        rx_data      = 8'hF0;
      end else if (k == 41) begin
        rx_done_tick = 1'b1;
        rx_data      = 8'h23;
      end
    end
    rx_done_tick = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_press_release();
    test_priority();
    test_player1();
    test_typematic();
    test_prefix_reset();
    test_unmapped();
    test_back_to_back();
    test_repeat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
